// File: rtl/srambank_banked_init.sv
// srambank_banked_init: banked single-port SRAM behavioural model with
// per-byte write masks, a valid/ready request port, a one-cycle read
// response strobe and a zero-initialise sweep that runs after every reset.
// Optional build macro: SRAMBANK_OUTREG_EN adds one output pipeline stage
// on the read response (read latency 2 instead of 1).
module srambank_banked_init #(
    parameter int WORDS  = 512,
    parameter int WIDTH  = 32,
    parameter int NBANKS = 4,
    localparam int AW    = $clog2(WORDS),
    localparam int NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [NB-1:0]    req_wmask,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             init_done
);

    localparam int BW    = $clog2(NBANKS);
    localparam int DEPTH = WORDS / NBANKS;
    // Bank and row selects keep at least one bit so single-bank or
    // single-row configurations still elaborate cleanly.
    localparam int BWX   = (BW > 0) ? BW : 1;
    localparam int RAW   = ((AW - BW) > 0) ? (AW - BW) : 1;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t           state_q;
    logic [RAW-1:0]   initPtr_q;
    logic [RAW-1:0]   initPtr_d;
    logic             reqReady_q;
    logic             initDone_q;
    logic [BWX-1:0]   bankSel;
    logic [RAW-1:0]   rowSel;
    logic             accept;
    logic             readAcc;
    logic             writeAcc;
    logic             rspValid_q;
    logic [WIDTH-1:0] rspData_q;
    logic [WIDTH-1:0] mem_q [NBANKS][DEPTH];

    // Split the word address into bank (upper bits) and row (lower bits);
    // a transfer only happens in IDLE and never in a reset cycle.
    always_comb begin
        bankSel = '0;
        rowSel  = '0;
        if (NBANKS > 1) begin
            bankSel = req_addr[AW-1 -: BWX];
        end
        if (DEPTH > 1) begin
            rowSel = req_addr[RAW-1:0];
        end
        initPtr_d = initPtr_q + RAW'(1);
        accept    = req_valid & reqReady_q & ~reset;
        readAcc   = accept & ~req_write;
        writeAcc  = accept & req_write;
    end

    // Control FSM: sweep every row once after reset, then sit in IDLE
    // accepting requests; ready and done are registered with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            initPtr_q  <= '0;
            reqReady_q <= 1'b0;
            initDone_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    initPtr_q <= initPtr_d;
                    if (initPtr_q == RAW'(DEPTH - 1)) begin
                        state_q    <= IDLE;
                        initPtr_q  <= '0;
                        reqReady_q <= 1'b1;
                        initDone_q <= 1'b1;
                    end
                end
                IDLE: begin
                    reqReady_q <= 1'b1;
                    initDone_q <= 1'b1;
                end
                default: begin
                    state_q    <= INIT;
                    initPtr_q  <= '0;
                    reqReady_q <= 1'b0;
                    initDone_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep zeroes one row in all banks at once; otherwise an
    // accepted write updates only the bytes whose mask bit is set.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            for (int b = 0; b < NBANKS; b++) begin
                mem_q[b][initPtr_q] <= '0;
            end
        end else if (writeAcc) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wmask[i]) begin
                    mem_q[bankSel][rowSel][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read response: data is captured on the accepting edge and held until
    // the next read; the valid strobe lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
        end else begin
            rspValid_q <= readAcc;
            if (readAcc) begin
                rspData_q <= mem_q[bankSel][rowSel];
            end
        end
    end

`ifdef SRAMBANK_OUTREG_EN
    logic             rspValidOut_q;
    logic [WIDTH-1:0] rspDataOut_q;

    // Extra output stage: valid and data move together, one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspValidOut_q <= 1'b0;
            rspDataOut_q  <= '0;
        end else begin
            rspValidOut_q <= rspValid_q;
            rspDataOut_q  <= rspData_q;
        end
    end

    assign rsp_valid = rspValidOut_q;
    assign rsp_data  = rspDataOut_q;
`else
    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
`endif

    assign req_ready = reqReady_q;
    assign init_done = initDone_q;

endmodule

// File: tb/tb_srambank_banked_init.sv
// tb_srambank_banked_init: directed bench for srambank_banked_init with a
// cycle-level reference model and a per-cycle output compare.
module tb_srambank_banked_init;

    localparam int WORDS  = 512;
    localparam int WIDTH  = 32;
    localparam int NBANKS = 4;
    localparam int DEPTH  = WORDS / NBANKS;
`ifdef SRAMBANK_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;

    int compared   = 0;
    int mismatched = 0;

    srambank_banked_init #(
        .WORDS (WORDS),
        .WIDTH (WIDTH),
        .NBANKS(NBANKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .init_done(init_done)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [31:0] b32(input logic b);
        return {31'b0, b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: a flat word array, a count of clean cycles since reset
    // and a LAT-deep response pipe.
    bit [31:0] mMem [WORDS];
    int        mInitCount = 0;
    bit        mReady     = 1'b0;
    bit        mAcc;
    bit        mValid [2];
    bit [31:0] mData [2];
    bit        modelLive  = 1'b0;

    // Advance the model on every rising edge using the inputs sampled there.
    always @(posedge clk) begin
        if (reset) begin
            foreach (mMem[i]) mMem[i] = '0;
            mInitCount = 0;
            mReady     = 1'b0;
            mValid[0]  = 1'b0;
            mValid[1]  = 1'b0;
            mData[0]   = '0;
            mData[1]   = '0;
            modelLive  = 1'b1;
        end else begin
            mAcc      = req_valid && mReady;
            mValid[1] = mValid[0];
            mData[1]  = mData[0];
            mValid[0] = mAcc && !req_write;
            if (mAcc && !req_write) mData[0] = mMem[req_addr];
            if (mAcc && req_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_wmask[i]) mMem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                end
            end
            if (mInitCount < DEPTH) mInitCount++;
            mReady = (mInitCount == DEPTH);
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("cyc_req_ready", b32(req_ready), b32(mReady));
            checkOutput("cyc_init_done", b32(init_done), b32(mReady));
            checkOutput("cyc_rsp_valid", b32(rsp_valid), b32(mValid[LAT-1]));
            checkOutput("cyc_rsp_data", rsp_data, mData[LAT-1]);
        end
    end

    // Drive one request for exactly one clock edge, then drop req_valid.
    task automatic applyStimulus(input logic v, input logic w, input logic [8:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Count the not-ready cycles after reset release, bounded.
    task automatic waitInit(input string name);
        int cnt;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 1000) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput(name, cnt, DEPTH);
        checkOutput({name, "_done"}, b32(init_done), 32'd1);
    endtask

    task automatic readCheck(input logic [8:0] a, input logic [31:0] exp, input string name);
        applyStimulus(1'b1, 1'b0, a, '0, '0);
        repeat (LAT - 1) applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput({name, "_v"}, b32(rsp_valid), 32'd1);
        checkOutput({name, "_d"}, rsp_data, exp);
    endtask

    logic        sV [5];
    logic [31:0] sD [5];

    // Directed sequence with hand-computed expectations.
    initial begin
        resetDut();
        waitInit("init_len");
        readCheck(9'h1FF, 32'h0000_0000, "rd_1ff");

        applyStimulus(1'b1, 1'b1, 9'h005, 32'hAABB_CCDD, 4'hF);
        applyStimulus(1'b1, 1'b1, 9'h005, 32'h1122_3344, 4'b0101);
        readCheck(9'h005, 32'hAA22_CC44, "mask");
        applyStimulus(1'b1, 1'b1, 9'h005, 32'hFFFF_FFFF, 4'h0);
        readCheck(9'h005, 32'hAA22_CC44, "noop");

        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 9'(k * 128), 32'hDEAD_0000 + 32'(k), 4'hF);
        for (int k = 0; k < 4; k++)
            readCheck(9'(k * 128), 32'hDEAD_0000 + 32'(k), $sformatf("bank%0d", k));

        applyStimulus(1'b1, 1'b1, 9'h0A0, 32'h1234_5678, 4'hF);
        sV[0] = rsp_valid; sD[0] = rsp_data;
        applyStimulus(1'b1, 1'b0, 9'h0A0, '0, '0);
        sV[1] = rsp_valid; sD[1] = rsp_data;
        applyStimulus(1'b1, 1'b0, 9'h0A1, '0, '0);
        sV[2] = rsp_valid; sD[2] = rsp_data;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        sV[3] = rsp_valid; sD[3] = rsp_data;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        sV[4] = rsp_valid; sD[4] = rsp_data;
        checkOutput("b2b_pre_v", b32(sV[LAT-1]), 32'd0);
        checkOutput("b2b_first_v", b32(sV[LAT]), 32'd1);
        checkOutput("b2b_first_d", sD[LAT], 32'h1234_5678);
        checkOutput("b2b_second_v", b32(sV[LAT+1]), 32'd1);
        checkOutput("b2b_second_d", sD[LAT+1], 32'h0000_0000);
        checkOutput("b2b_hold_v", b32(sV[LAT+2]), 32'd0);
        checkOutput("b2b_hold_d", sD[LAT+2], 32'h0000_0000);

        applyStimulus(1'b1, 1'b0, 9'h005, '0, '0);
        repeat (LAT - 1) applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rstrsp_pre_v", b32(rsp_valid), 32'd1);
        checkOutput("rstrsp_pre_d", rsp_data, 32'hAA22_CC44);
        resetDut();
        checkOutput("rstrsp_v", b32(rsp_valid), 32'd0);
        checkOutput("rstrsp_d", rsp_data, 32'h0000_0000);
        waitInit("reinit_len");
        readCheck(9'h005, 32'h0000_0000, "rezero");

        resetDut();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h0A0;
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midsweep_ready", b32(req_ready), 32'd0);
        resetDut();
        waitInit("sweep_restart_len");
        req_valid = 1'b0;

        applyStimulus(1'b1, 1'b1, 9'h005, 32'h0000_BEEF, 4'hF);
        applyStimulus(1'b1, 1'b0, 9'h005, '0, '0);
`ifdef SRAMBANK_OUTREG_EN
        checkOutput("lat2_early_v", b32(rsp_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
`endif
        checkOutput("beef_v", b32(rsp_valid), 32'd1);
        checkOutput("beef_d", rsp_data, 32'h0000_BEEF);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
